ram_arbiter: RTL and testbench

//   Two-port arbiter/sequencer in front of the single-port byte-addressable RAM.

---
 rtl/ram_arbiter_if.sv | 46 ++++
 rtl/ram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// The slave side is the arbiter; the master side is its environment
// (instruction-fetch master, load/store master and the RAM itself).
interface ram_arbiter_if;
   logic        m0_req;
   logic [15:0] m0_addr;
   logic [15:0] m0_wdata;
   logic [1:0]  m0_be;
   logic        m0_we;
   logic        m0_ack;
   logic [15:0] m0_rdata;
   logic        m0_err;

   logic        m1_req;
   logic [15:0] m1_addr;
   logic [15:0] m1_wdata;
   logic [1:0]  m1_be;
   logic        m1_we;
   logic        m1_ack;
   logic [15:0] m1_rdata;
   logic        m1_err;

   logic [15:0] ram_address;
   logic [15:0] ram_data_in;
   logic [1:0]  ram_be;
   logic        ram_we;
   logic [15:0] ram_data_out;

   modport slave (
      input  m0_req, m0_addr, m0_wdata, m0_be, m0_we,
      output m0_ack, m0_rdata, m0_err,
      input  m1_req, m1_addr, m1_wdata, m1_be, m1_we,
      output m1_ack, m1_rdata, m1_err,
      output ram_address, ram_data_in, ram_be, ram_we,
      input  ram_data_out
   );

   modport master (
      output m0_req, m0_addr, m0_wdata, m0_be, m0_we,
      input  m0_ack, m0_rdata, m0_err,
      output m1_req, m1_addr, m1_wdata, m1_be, m1_we,
      input  m1_ack, m1_rdata, m1_err,
      input  ram_address, ram_data_in, ram_be, ram_we,
      output ram_data_out
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter/sequencer in front of a single-port byte-addressable RAM.
// Every access takes IDLE -> ACCESS -> RESP; the granted request is latched,
// range-checked, driven to the RAM for one cycle and answered with an ack pulse.
module ram_arbiter #(
   parameter int unsigned MEM_BYTES = 256,
   parameter bit          PRIO_MODE = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   ram_arbiter_if.slave bus,
   output logic         busy
);

   localparam int unsigned AW        = 16;
   localparam int unsigned DW        = 16;
   localparam int unsigned BEW       = 2;
   localparam int unsigned LAST_ADDR = MEM_BYTES - 1;
   localparam logic [BEW-1:0] BE_BYTE = 2'b01;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           rr_q, rr_d;            // 0 = master 0 holds the turn
   logic           id_q, id_d;            // granted master
   logic [AW-1:0]  addr_q, addr_d;
   logic [DW-1:0]  wdata_q, wdata_d;
   logic [BEW-1:0] be_q, be_d;
   logic           we_q, we_d;
   logic           err_q, err_d;
   logic           ram_we_q, ram_we_d;
   logic           m0_ack_q, m0_ack_d;
   logic           m1_ack_q, m1_ack_d;
   logic [DW-1:0]  m0_rdata_q, m0_rdata_d;
   logic [DW-1:0]  m1_rdata_q, m1_rdata_d;
   logic           m0_err_q, m0_err_d;
   logic           m1_err_q, m1_err_d;
   logic           busy_q, busy_d;

   logic           gnt1_c;
   logic [DW-1:0]  rd_val_c;

   // Next-state, grant, latch and response computation
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      id_d       = id_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      we_d       = we_q;
      err_d      = err_q;
      ram_we_d   = 1'b0;
      m0_ack_d   = 1'b0;
      m1_ack_d   = 1'b0;
      m0_rdata_d = '0;
      m1_rdata_d = '0;
      m0_err_d   = 1'b0;
      m1_err_d   = 1'b0;

      // master 1 wins when alone, or on a tie when round-robin points at it
      gnt1_c   = bus.m1_req & (~bus.m0_req | (~PRIO_MODE & rr_q));
      rd_val_c = err_q ? '0 :
                 ((be_q == BE_BYTE) ? {8'h00, bus.ram_data_out[7:0]} : bus.ram_data_out);

      case (state_q)
         IDLE: begin
            if (bus.m0_req | bus.m1_req) begin
               id_d     = gnt1_c;
               addr_d   = gnt1_c ? bus.m1_addr  : bus.m0_addr;
               wdata_d  = gnt1_c ? bus.m1_wdata : bus.m0_wdata;
               be_d     = gnt1_c ? bus.m1_be    : bus.m0_be;
               we_d     = gnt1_c ? bus.m1_we    : bus.m0_we;
               // a word access at the last byte would spill past the RAM
               err_d    = (32'(addr_d) >= MEM_BYTES) |
                          ((be_d != BE_BYTE) & (32'(addr_d) == LAST_ADDR));
               ram_we_d = we_d & ~err_d;
               rr_d     = ~rr_q;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (id_q) begin
               m1_ack_d   = 1'b1;
               m1_rdata_d = rd_val_c;
               m1_err_d   = err_q;
            end else begin
               m0_ack_d   = 1'b1;
               m0_rdata_d = rd_val_c;
               m0_err_d   = err_q;
            end
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset abandons any access in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         id_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         ram_we_q   <= 1'b0;
         m0_ack_q   <= 1'b0;
         m1_ack_q   <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         m0_err_q   <= 1'b0;
         m1_err_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         id_q       <= id_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         we_q       <= we_d;
         err_q      <= err_d;
         ram_we_q   <= ram_we_d;
         m0_ack_q   <= m0_ack_d;
         m1_ack_q   <= m1_ack_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
         m0_err_q   <= m0_err_d;
         m1_err_q   <= m1_err_d;
         busy_q     <= busy_d;
      end
   end

   // RAM side is driven straight from the access latch
   assign bus.ram_address = addr_q;
   assign bus.ram_data_in = wdata_q;
   assign bus.ram_be      = be_q;
   assign bus.ram_we      = ram_we_q;

   assign bus.m0_ack   = m0_ack_q;
   assign bus.m0_rdata = m0_rdata_q;
   assign bus.m0_err   = m0_err_q;
   assign bus.m1_ack   = m1_ack_q;
   assign bus.m1_rdata = m1_rdata_q;
   assign bus.m1_err   = m1_err_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: instance 0 uses round-robin, instance 1 fixed priority.
// Each instance sits in front of its own byte RAM; a reference RAM image
// predicts every response, which is queued at stimulus time and checked on ack.
module tb_ram_arbiter;

   localparam int unsigned MEM_BYTES = 256;

   typedef struct packed {
      logic        id;
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic mem_clr;

   logic [1:0][1:0]        req_r, we_r, ack_w, err_w;
   logic [1:0][1:0][15:0]  addr_r, wdata_r, rdata_w;
   logic [1:0][1:0][1:0]   be_r;
   logic [1:0]             ram_we_w, busy_w;
   logic [1:0][15:0]       ram_addr_w, ram_din_w;
   logic [1:0][1:0]        ram_be_w;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   we_cnt [2];
   exp_t sb0 [$];
   exp_t sb1 [$];
   logic [7:0] mdl [2][MEM_BYTES];

   always #5 clk = ~clk;

   // Two arbiters, each with its own RAM
   for (genvar d = 0; d < 2; d++) begin : g_dut
      ram_arbiter_if bus ();
      logic [7:0]  mem [MEM_BYTES];
      logic [15:0] rd_c;
      logic [7:0]  a8;

      assign bus.m0_req   = req_r[d][0];
      assign bus.m0_addr  = addr_r[d][0];
      assign bus.m0_wdata = wdata_r[d][0];
      assign bus.m0_be    = be_r[d][0];
      assign bus.m0_we    = we_r[d][0];
      assign bus.m1_req   = req_r[d][1];
      assign bus.m1_addr  = addr_r[d][1];
      assign bus.m1_wdata = wdata_r[d][1];
      assign bus.m1_be    = be_r[d][1];
      assign bus.m1_we    = we_r[d][1];
      assign ack_w[d][0]   = bus.m0_ack;
      assign rdata_w[d][0] = bus.m0_rdata;
      assign err_w[d][0]   = bus.m0_err;
      assign ack_w[d][1]   = bus.m1_ack;
      assign rdata_w[d][1] = bus.m1_rdata;
      assign err_w[d][1]   = bus.m1_err;
      assign ram_we_w[d]   = bus.ram_we;
      assign ram_addr_w[d] = bus.ram_address;
      assign ram_din_w[d]  = bus.ram_data_in;
      assign ram_be_w[d]   = bus.ram_be;
      assign a8            = bus.ram_address[7:0];

      // RAM read: byte access returns the addressed byte in [7:0],
      // word access returns {byte[a], byte[a+1]}
      always_comb begin
         rd_c = 16'h0000;
         if (32'(bus.ram_address) < MEM_BYTES) begin
            if (bus.ram_be == 2'b01)
               rd_c = {8'h00, mem[a8]};
            else if (32'(bus.ram_address) + 1 < MEM_BYTES)
               rd_c = {mem[a8], mem[8'(a8 + 8'd1)]};
         end
      end
      assign bus.ram_data_out = rd_c;

      always_ff @(posedge clk) begin
         if (mem_clr) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'h00;
         end else if (bus.ram_we && 32'(bus.ram_address) < MEM_BYTES) begin
            if (bus.ram_be == 2'b01) begin
               mem[a8] <= bus.ram_data_in[7:0];
            end else begin
               mem[a8] <= bus.ram_data_in[15:8];
               if (32'(bus.ram_address) + 1 < MEM_BYTES)
                  mem[8'(a8 + 8'd1)] <= bus.ram_data_in[7:0];
            end
         end
      end

      ram_arbiter #(.MEM_BYTES(MEM_BYTES), .PRIO_MODE(1'(d))) u_dut (
         .clk  (clk),
         .reset(reset),
         .bus  (bus),
         .busy (busy_w[d])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Predict the response of one access and update the reference RAM image
   task automatic push_exp(input int d, input int m, input logic [15:0] a,
                           input logic [15:0] wd, input logic [1:0] be, input logic we);
      exp_t e;
      int   ai;
      ai      = int'(a);
      e.id    = m[0];
      e.err   = (ai >= int'(MEM_BYTES)) || (be != 2'b01 && ai == int'(MEM_BYTES) - 1);
      e.rdata = 16'h0000;
      if (!e.err) begin
         if (be == 2'b01) e.rdata = {8'h00, mdl[d][ai]};
         else             e.rdata = {mdl[d][ai], mdl[d][ai+1]};
         if (we) begin
            if (be == 2'b01) begin
               mdl[d][ai] = wd[7:0];
            end else begin
               mdl[d][ai]   = wd[15:8];
               mdl[d][ai+1] = wd[7:0];
            end
         end
      end
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   // One master access: wait for IDLE, hold req until ack, then drop it
   task automatic drive(input int d, input int m, input logic [15:0] a, input logic [15:0] wd,
                        input logic [1:0] be, input logic we, input int exp_lat);
      int n;
      n = 0;
      while (busy_w[d] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      addr_r[d][m]  = a;
      wdata_r[d][m] = wd;
      be_r[d][m]    = be;
      we_r[d][m]    = we;
      req_r[d][m]   = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ack_w[d][m] && n < 20);
      chk($sformatf("d%0d_m%0d_ack_seen", d, m), 32'(ack_w[d][m]), 32'd1);
      if (exp_lat > 0) chk($sformatf("d%0d_m%0d_latency", d, m), 32'(n), 32'(exp_lat));
      req_r[d][m] = 1'b0;
   endtask

   task automatic mon_ack(input int d, input int m);
      exp_t e;
      int   left;
      left = (d == 0) ? sb0.size() : sb1.size();
      chk($sformatf("d%0d_unexpected_ack", d), 32'(left > 0), 32'd1);
      if (left > 0) begin
         if (d == 0) e = sb0.pop_front();
         else        e = sb1.pop_front();
         chk($sformatf("d%0d_grant_id", d), 32'(m), 32'(e.id));
         chk($sformatf("d%0d_m%0d_rdata", d, m), 32'(rdata_w[d][m]), 32'(e.rdata));
         chk($sformatf("d%0d_m%0d_err", d, m), 32'(err_w[d][m]), 32'(e.err));
         chk($sformatf("d%0d_other_quiet", d),
             {15'h0, ack_w[d][1-m], rdata_w[d][1-m]}, 32'd0);
         chk($sformatf("d%0d_other_err", d), 32'(err_w[d][1-m]), 32'd0);
      end
   endtask

   // Response monitor and write-strobe counter
   always @(negedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            if (ram_we_w[d]) we_cnt[d]++;
            for (int m = 0; m < 2; m++)
               if (ack_w[d][m]) mon_ack(d, m);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, seen, acks, last, idle_cnt, cyc;
      req_r = '0; we_r = '0; addr_r = '0; wdata_r = '0; be_r = '0;
      we_cnt[0] = 0; we_cnt[1] = 0;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < int'(MEM_BYTES); i++) mdl[d][i] = 8'h00;
      reset   = 1'b1;
      mem_clr = 1'b1;
      #2;
      chk("rst_acks",  32'(ack_w), 32'd0);
      chk("rst_errs",  32'(err_w), 32'd0);
      chk("rst_rdata0", 32'(rdata_w[0]), 32'd0);
      chk("rst_rdata1", 32'(rdata_w[1]), 32'd0);
      chk("rst_ram_we", 32'(ram_we_w), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr_w), 32'd0);
      chk("rst_ram_din", 32'(ram_din_w), 32'd0);
      chk("rst_ram_be", 32'(ram_be_w), 32'd0);
      chk("rst_busy", 32'(busy_w), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      mem_clr = 1'b0;
      reset   = 1'b0;

      // known contents at 0x40, then abandon an m1 overwrite with reset
      push_exp(0, 0, 16'h0040, 16'h1234, 2'b11, 1'b1);
      drive(0, 0, 16'h0040, 16'h1234, 2'b11, 1'b1, 2);
      @(posedge clk); #1;
      addr_r[0][1] = 16'h0040; wdata_r[0][1] = 16'h5555; be_r[0][1] = 2'b11;
      we_r[0][1] = 1'b1; req_r[0][1] = 1'b1;
      @(posedge clk); #1;
      chk("abort_we_before_rst", 32'(ram_we_w[0]), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_we_drops", 32'(ram_we_w[0]), 32'd0);
      chk("abort_busy_drops", 32'(busy_w[0]), 32'd0);
      @(posedge clk); #1;
      req_r[0][1] = 1'b0;
      reset = 1'b0;
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (ack_w[0][1] || busy_w[0]) seen++;
      end
      chk("abort_no_ack", 32'(seen), 32'd0);
      push_exp(0, 1, 16'h0040, 16'h0000, 2'b11, 1'b0);
      drive(0, 1, 16'h0040, 16'h0000, 2'b11, 1'b0, 2);

      // word write then read back; byte read of the low byte
      w0 = we_cnt[0];
      push_exp(0, 0, 16'h0010, 16'hBEEF, 2'b11, 1'b1);
      drive(0, 0, 16'h0010, 16'hBEEF, 2'b11, 1'b1, 2);
      chk("write_we_cycles", 32'(we_cnt[0] - w0), 32'd1);
      push_exp(0, 0, 16'h0010, 16'h0000, 2'b11, 1'b0);
      drive(0, 0, 16'h0010, 16'h0000, 2'b11, 1'b0, 2);
      push_exp(0, 1, 16'h0011, 16'h0000, 2'b01, 1'b0);
      drive(0, 1, 16'h0011, 16'h0000, 2'b01, 1'b0, 2);

      // range errors never write; last-byte byte write is legal
      w0 = we_cnt[0];
      push_exp(0, 1, 16'h00FF, 16'hCAFE, 2'b11, 1'b1);
      drive(0, 1, 16'h00FF, 16'hCAFE, 2'b11, 1'b1, 2);
      push_exp(0, 0, 16'h0100, 16'h0000, 2'b01, 1'b0);
      drive(0, 0, 16'h0100, 16'h0000, 2'b01, 1'b0, 2);
      chk("err_no_write", 32'(we_cnt[0] - w0), 32'd0);
      push_exp(0, 0, 16'h00FF, 16'h00A5, 2'b01, 1'b1);
      drive(0, 0, 16'h00FF, 16'h00A5, 2'b01, 1'b1, 2);
      chk("last_byte_write", 32'(we_cnt[0] - w0), 32'd1);
      push_exp(0, 1, 16'h00FF, 16'h0000, 2'b01, 1'b0);
      drive(0, 1, 16'h00FF, 16'h0000, 2'b01, 1'b0, 2);
      push_exp(0, 1, 16'h00FE, 16'h0000, 2'b10, 1'b0);
      drive(0, 1, 16'h00FE, 16'h0000, 2'b10, 1'b0, 2);

      // arbitration from a fresh round-robin pointer
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int r = 0; r < 3; r++) begin
         push_exp(0, 0, 16'h0030, 16'(32'h2200 + r), 2'b11, 1'b1);
         push_exp(0, 1, 16'h0030, 16'h0000, 2'b11, 1'b0);
         fork
            drive(0, 0, 16'h0030, 16'(32'h2200 + r), 2'b11, 1'b1, 2);
            drive(0, 1, 16'h0030, 16'h0000, 2'b11, 1'b0, 5);
         join
      end
      // a lone m0 grant hands the turn to m1
      push_exp(0, 0, 16'h0010, 16'h0000, 2'b11, 1'b0);
      drive(0, 0, 16'h0010, 16'h0000, 2'b11, 1'b0, 2);
      push_exp(0, 1, 16'h0011, 16'h0000, 2'b01, 1'b0);
      push_exp(0, 0, 16'h0030, 16'h0000, 2'b11, 1'b0);
      fork
         drive(0, 1, 16'h0011, 16'h0000, 2'b01, 1'b0, 2);
         drive(0, 0, 16'h0030, 16'h0000, 2'b11, 1'b0, 5);
      join

      // fixed priority: m0 always first
      for (int r = 0; r < 3; r++) begin
         push_exp(1, 0, 16'h0020, 16'(32'h1100 + r), 2'b11, 1'b1);
         push_exp(1, 1, 16'h0020, 16'h0000, 2'b11, 1'b0);
         fork
            drive(1, 0, 16'h0020, 16'(32'h1100 + r), 2'b11, 1'b1, 2);
            drive(1, 1, 16'h0020, 16'h0000, 2'b11, 1'b0, 5);
         join
      end
      push_exp(1, 0, 16'h0020, 16'h0000, 2'b11, 1'b0);
      drive(1, 0, 16'h0020, 16'h0000, 2'b11, 1'b0, 2);
      push_exp(1, 0, 16'h0020, 16'h1199, 2'b11, 1'b1);
      push_exp(1, 1, 16'h0020, 16'h0000, 2'b11, 1'b0);
      fork
         drive(1, 0, 16'h0020, 16'h1199, 2'b11, 1'b1, 2);
         drive(1, 1, 16'h0020, 16'h0000, 2'b11, 1'b0, 5);
      join

      // back-to-back reads with req held high
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) push_exp(0, 0, 16'h0010, 16'h0000, 2'b11, 1'b0);
      addr_r[0][0] = 16'h0010; be_r[0][0] = 2'b11; we_r[0][0] = 1'b0; req_r[0][0] = 1'b1;
      acks = 0; last = -1; idle_cnt = 0; cyc = 0;
      while (acks < 4 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (!busy_w[0]) idle_cnt++;
         if (ack_w[0][0]) begin
            acks++;
            if (last >= 0) begin
               chk("cont_ack_gap", 32'(cyc - last), 32'd3);
               chk("cont_idle_gap", 32'(idle_cnt), 32'd1);
            end
            last = cyc;
            idle_cnt = 0;
            if (acks == 4) req_r[0][0] = 1'b0;
         end
      end
      chk("cont_acks", 32'(acks), 32'd4);

      repeat (4) @(posedge clk);
      #1;
      chk("sb0_drained", 32'(sb0.size()), 32'd0);
      chk("sb1_drained", 32'(sb1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
